csi_rx_chk: RTL
===============

# csi_rx_chk

Simulation-side AXI4-Stream video sink and checker, sitting at the consumer end of the camera-stream path. It accepts the 32-bit pixel stream produced by the CSI receive model or by the DUT's video output. It drives `tready` with a selectable backpressure pattern and checks the frame structure beat by beat:

- start-of-frame marker on `tuser`
- end-of-line marker on `tlast`
- line and frame geometry
- pixel payload against the expected pixel index

It reports frame completions and error counts to the testbench.

## Interface
Parameters:
- `WDT`, 640: active pixels per line.
- `HGT`, 480: lines per frame.
- `BP_MODE`, 0: tready pattern. 0 = always ready while enabled; 1 = LFSR-driven pseudo-random stall.
- `BP_SEED`, 16'hACE1: LFSR seed. Must be non-zero.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enb` in 1: checker enable; low forces resync.
- `tvalid` in 1: stream beat valid.
- `tready` out 1: sink ready; registered.
- `tuser` in 1: start of frame, on the first pixel of line 0.
- `tlast` in 1: end of line, on pixel `WDT-1`.
- `tdata` in 32: pixel; expected value is the pixel x index, zero-extended.
- `tdest` in 4: must be 0.
- `tkeep` in 4: must be 4'hF.
- `frm_done` out 1: one-cycle pulse per completed frame.
- `frm_cnt` out 16: completed frames, saturating.
- `err_cnt` out 16: beats carrying at least one error, saturating.
- `err_sof` out 1: sticky, SOF error seen.
- `err_eol` out 1: sticky, EOL error seen.
- `err_data` out 1: sticky, payload mismatch seen.
- `err_side` out 1: sticky, `tkeep`/`tdest` error seen.

## Operation
- **Beat acceptance.** A beat is accepted when `tvalid & tready` on a rising edge. Nothing else advances the state.
- **Position counters.** `x` runs over 0..WDT-1 and `y` over 0..HGT-1. Widths are `$clog2` of the respective parameter, minimum 1.
- **FSM states.** Two states: `WAIT_SOF` and `RUN`.
- **WAIT_SOF.**
  - Accepted beats without `tuser` are discarded with no error.
  - A beat with `tuser` is checked as pixel (0,0), then the FSM moves to `RUN` with x=1, y=0.
- **RUN, per accepted beat:**
  - `tuser=1` at (x,y) ≠ (0,0): set `err_sof`. Resync: the beat is pixel (0,0), next x=1, y=0. No `frm_done`.
  - `tuser=0` at (0,0): set `err_sof`; continue counting.
  - `tlast=1` with x≠WDT-1: set `err_eol`; next x=0, y+1.
  - `tlast=0` with x=WDT-1: set `err_eol`; still wrap to x=0, y+1.
  - `tdata` ≠ x: set `err_data`.
  - `tkeep` ≠ 4'hF or `tdest` ≠ 0: set `err_side`.
- **Error count.** `err_cnt` increments by exactly 1 per accepted beat with any error, regardless of how many error types that beat carries.
- **Frame completion.**
  - The beat at x=WDT-1, y=HGT-1 pulses `frm_done` and increments `frm_cnt`.
  - After that beat, the FSM returns to `WAIT_SOF`.
  - An erroneous `tlast` that moves y past HGT-1 also returns the FSM to `WAIT_SOF`, with no `frm_done`.
- **enb low.**
  - `tready` goes to 0 and the FSM goes to `WAIT_SOF`; x and y clear.
  - Counters and sticky flags hold.
  - The LFSR reloads `BP_SEED`.
- **Saturation.** `frm_cnt` and `err_cnt` saturate at 16'hFFFF.
- **Backpressure.**
  - BP_MODE 0: `tready` follows `enb` with one register stage.
  - BP_MODE 1: a 16-bit Fibonacci LFSR with taps 16,14,13,11 advances every enabled cycle. `tready` = `enb` & (lfsr[1:0] ≠ 2'b00), i.e. roughly 75% ready.

## Timing
- **Reset values.** On `rst`: `tready`=0, `frm_done`=0, `frm_cnt`=0, `err_cnt`=0, all sticky flags 0, FSM in `WAIT_SOF`, x=y=0, LFSR=`BP_SEED`.
- **Reset mid-frame.** Same as above. The next frame is accepted only after a fresh `tuser`.
- **tready latency.** `tready` is registered, so it rises 1 cycle after `enb` rises, and falls 1 cycle after `enb` falls.
- **Beat accepted in the cycle enb falls.** If `enb` falls while `tready` is still high, a beat accepted in that cycle is discarded unchecked.
- **Result latency.** Error flags, `err_cnt`, `frm_cnt` and `frm_done` update on the clock edge that accepts the beat, so they are visible the cycle after acceptance.
- **rst versus enb.** `rst` takes priority over `enb`.

## Structure
- Package `csi_chk_pkg` holds:
  - the FSM state enum (`WAIT_SOF`, `RUN`)
  - LFSR taps and width
  - BP_MODE encodings
  - the 16-bit counter width
- Sub-module `csi_bp_lfsr`: LFSR with seed reload on `!enb` and an advance enable. The top block does everything else.

## Test plan
- **Clean stream.** BP_MODE 0, WDT=8, HGT=4, two clean frames with `tdata`=x → `frm_done` pulses twice, `frm_cnt`=2, `err_cnt`=0, all sticky flags 0.
- **Random backpressure.** BP_MODE 1, the same two frames, source holding beats under stall → identical results; no beat is lost or duplicated.
- **Early tlast.** Line 1 with `tlast` at x=5 → `err_eol`=1, `err_cnt`=1. Line 2 starts at x=0. The frame still completes: `frm_done`=1, `frm_cnt`=1.
- **Payload and sideband errors.** One beat with `tdata`=32'hDEAD and `tkeep`=4'h7 in the same beat → `err_data`=1, `err_side`=1, `err_cnt`=1.
- **Mid-frame resync.** `tuser` at (3,2) → `err_sof`=1, no `frm_done` for the aborted frame. The following frame is counted in full.
- **Reset mid-frame.** `rst` pulsed at (4,1), then a clean frame → after reset all outputs are 0; after the clean frame `frm_cnt`=1, `err_cnt`=0.

Source files
------------

// File: rtl/csi_chk_pkg.sv
// Shared types and constants for the CSI stream checker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package csi_chk_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over [15:0].
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int BP_ALWAYS = 0;
  localparam int BP_RANDOM = 1;

  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/csi_bp_lfsr.sv
// 16-bit Fibonacci LFSR that paces the checker's tready stall pattern.
// Latency: new value one cycle after each advance; low bits exported directly from the register.
// Backpressure: none of its own; reloads the seed whenever the checker is disabled.
module csi_bp_lfsr
  import csi_chk_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enb,
  input  logic       i_adv,
  output logic [1:0] o_low
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb  = ^(r_lfsr & LFSR_TAPS);
  assign o_low = r_lfsr[1:0];

  // Seed on reset or while disabled, otherwise shift in the feedback bit.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enb) begin
      r_lfsr <= SEED;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/csi_rx_chk.sv
// AXI4-Stream video sink that checks SOF/EOL framing, geometry, payload and sideband per beat.
// Latency: flags, counters and frm_done update on the accepting edge (visible next cycle).
// Backpressure: registered tready, always-on or LFSR-driven ~75% duty, forced low when disabled.
module csi_rx_chk
  import csi_chk_pkg::*;
#(
  parameter int          WDT     = 640,
  parameter int          HGT     = 480,
  parameter int          BP_MODE = 0,
  parameter logic [15:0] BP_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              tvalid,
  output logic              tready,
  input  logic              tuser,
  input  logic              tlast,
  input  logic [31:0]       tdata,
  input  logic [3:0]        tdest,
  input  logic [3:0]        tkeep,
  output logic              frm_done,
  output logic [CNT_W-1:0]  frm_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sof,
  output logic              err_eol,
  output logic              err_data,
  output logic              err_side
);

  localparam int XW = (WDT > 1) ? $clog2(WDT) : 1;
  localparam int YW = (HGT > 1) ? $clog2(HGT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WDT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HGT - 1);

  state_t           r_state, w_nxt_state;
  logic [XW-1:0]    r_x, w_nxt_x, w_px;
  logic [YW-1:0]    r_y, w_nxt_y, w_py;
  logic             r_tready;
  logic             r_frm_done;
  logic [CNT_W-1:0] r_frm_cnt, r_err_cnt;
  logic             r_err_sof, r_err_eol, r_err_data, r_err_side;
  logic [1:0]       w_lfsr_lo;
  logic             w_live, w_check;
  logic             w_x_end, w_y_end, w_line_end, w_frame_end;
  logic             w_sof_err, w_eol_err, w_data_err, w_side_err, w_any_err;

  csi_bp_lfsr #(
    .SEED (BP_SEED)
  ) u_lfsr (
    .i_clk (clk),
    .i_rst (rst),
    .i_enb (enb),
    .i_adv (enb),
    .o_low (w_lfsr_lo)
  );

  // Classify the current beat and work out the next position and state.
  always_comb begin
    // A beat taken while enb is already low is dropped unchecked.
    w_live      = tvalid & r_tready & enb;
    w_check     = w_live & ((r_state == RUN) | tuser);
    // tuser always re-anchors the beat at pixel (0,0).
    w_px        = tuser ? '0 : r_x;
    w_py        = tuser ? '0 : r_y;
    w_x_end     = (w_px == X_LAST);
    w_y_end     = (w_py == Y_LAST);
    w_line_end  = tlast | w_x_end;
    w_frame_end = w_x_end & w_y_end;
    w_sof_err   = (r_state == RUN) &
                  (tuser ? ((r_x != '0) | (r_y != '0)) : ((r_x == '0) & (r_y == '0)));
    w_eol_err   = tlast ^ w_x_end;
    w_data_err  = (tdata != 32'(w_px));
    w_side_err  = (tkeep != 4'hF) | (tdest != 4'h0);
    w_any_err   = w_sof_err | w_eol_err | w_data_err | w_side_err;

    w_nxt_state = r_state;
    w_nxt_x     = r_x;
    w_nxt_y     = r_y;
    if (!enb) begin
      w_nxt_state = WAIT_SOF;
      w_nxt_x     = '0;
      w_nxt_y     = '0;
    end else if (w_check) begin
      if (w_line_end) begin
        w_nxt_x = '0;
        // Leaving the last line, whether cleanly or via a stray tlast, ends the frame.
        if (w_y_end) begin
          w_nxt_state = WAIT_SOF;
          w_nxt_y     = '0;
        end else begin
          w_nxt_state = RUN;
          w_nxt_y     = w_py + YW'(1);
        end
      end else begin
        w_nxt_state = RUN;
        w_nxt_x     = w_px + XW'(1);
        w_nxt_y     = w_py;
      end
    end
  end

  // FSM state and pixel position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_SOF;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_x     <= w_nxt_x;
      r_y     <= w_nxt_y;
    end
  end

  // Registered tready: follows enb, optionally gated by the LFSR low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= enb & ((BP_MODE == BP_RANDOM) ? (w_lfsr_lo != 2'b00) : 1'b1);
    end
  end

  // Frame pulse, saturating counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frm_done <= 1'b0;
      r_frm_cnt  <= '0;
      r_err_cnt  <= '0;
      r_err_sof  <= 1'b0;
      r_err_eol  <= 1'b0;
      r_err_data <= 1'b0;
      r_err_side <= 1'b0;
    end else begin
      r_frm_done <= w_check & w_frame_end;
      if (w_check) begin
        if (w_frame_end) r_frm_cnt  <= sat_inc(r_frm_cnt);
        if (w_any_err)   r_err_cnt  <= sat_inc(r_err_cnt);
        if (w_sof_err)   r_err_sof  <= 1'b1;
        if (w_eol_err)   r_err_eol  <= 1'b1;
        if (w_data_err)  r_err_data <= 1'b1;
        if (w_side_err)  r_err_side <= 1'b1;
      end
    end
  end

  assign tready   = r_tready;
  assign frm_done = r_frm_done;
  assign frm_cnt  = r_frm_cnt;
  assign err_cnt  = r_err_cnt;
  assign err_sof  = r_err_sof;
  assign err_eol  = r_err_eol;
  assign err_data = r_err_data;
  assign err_side = r_err_side;

endmodule
